// File: rtl/ssp_serdes_param.sv
// Synchronous serial port: parameterized TX serializer with frame sync,
// and an RX deserializer fed either externally or by internal loopback.
module ssp_serdes_param #(
    parameter int unsigned WIDTH     = 8,
    parameter int unsigned DIV       = 2,
    parameter int unsigned LSB_FIRST = 0
) (
    input  logic             PCLK,
    input  logic             CLEAR_B,
    input  logic             SSPCLKIN,
    input  logic             SSPFSSIN,
    input  logic             SSPRXD,
    input  logic             LOOPBACK,
    input  logic [WIDTH-1:0] TxData,
    input  logic             TxIsEmpty,
    output logic             TxNextWord,
    output logic [WIDTH-1:0] RxData,
    output logic             RxNextWord,
    output logic             SSPCLKOUT,
    output logic             SSPFSSOUT,
    output logic             SSPTXD,
    output logic             SSPOE_B
);

    localparam int unsigned DIV_W = (DIV > 2) ? $clog2(DIV) : 1;
    localparam int unsigned CNT_W = $clog2(WIDTH + 1);

    typedef enum logic [2:0] {
        TX_IDLE,
        TX_LOAD,
        TX_SHIFT,
        TX_LAST,
        TX_LAST_LOAD
    } tx_state_t;

    typedef enum logic {
        RX_IDLE,
        RX_ACTIVE
    } rx_state_t;

    logic [DIV_W-1:0] div_cnt;
    logic             tick;

    tx_state_t        tx_state_q, tx_state_d;
    logic [CNT_W-1:0] tx_cnt_q, tx_cnt_d;
    logic [WIDTH-1:0] shift_out_q, shift_out_d;
    logic             fss_d;
    logic             oe_b_d;

    rx_state_t        rx_state_q, rx_state_d;
    logic [CNT_W-1:0] rx_cnt_q, rx_cnt_d;
    logic [WIDTH-1:0] shift_in_q, shift_in_d;
    logic [WIDTH-1:0] rx_data_d;
    logic             rx_push_d;
    logic             rx_clk, rx_fss, rx_dat;
    logic             clk_prev;
    logic             fall;

    assign tick = (div_cnt == DIV_W'(DIV - 1));

    // Clock divider and 50% duty serial clock, rising on the tick edge
    always_ff @(posedge PCLK or negedge CLEAR_B) begin
        if (!CLEAR_B) begin
            div_cnt   <= '0;
            SSPCLKOUT <= 1'b0;
        end else begin
            if (tick) begin
                div_cnt   <= '0;
                SSPCLKOUT <= 1'b1;
            end else begin
                div_cnt <= div_cnt + DIV_W'(1);
                if (div_cnt == DIV_W'(DIV / 2 - 1)) begin
                    SSPCLKOUT <= 1'b0;
                end
            end
        end
    end

    // TX next-state: every update is gated by tick
    always_comb begin
        tx_state_d  = tx_state_q;
        tx_cnt_d    = tx_cnt_q;
        shift_out_d = shift_out_q;
        fss_d       = SSPFSSOUT;
        oe_b_d      = SSPOE_B;
        if (tick) begin
            if (LSB_FIRST != 0) begin
                shift_out_d = {1'b0, shift_out_q[WIDTH-1:1]};
            end else begin
                shift_out_d = {shift_out_q[WIDTH-2:0], 1'b0};
            end
            case (tx_state_q)
                TX_IDLE: begin
                    if (!TxIsEmpty) begin
                        tx_state_d = TX_LOAD;
                    end
                end
                TX_LOAD, TX_LAST_LOAD: begin
                    shift_out_d = TxData;
                    tx_cnt_d    = CNT_W'(WIDTH - 1);
                    tx_state_d  = TX_SHIFT;
                end
                TX_SHIFT: begin
                    tx_cnt_d = tx_cnt_q - CNT_W'(1);
                    if (tx_cnt_q == CNT_W'(1)) begin
                        tx_state_d = TxIsEmpty ? TX_LAST : TX_LAST_LOAD;
                    end
                end
                TX_LAST: begin
                    tx_state_d = TX_IDLE;
                end
                default: begin
                    tx_state_d = TX_IDLE;
                end
            endcase
            fss_d  = (tx_state_d == TX_LOAD) || (tx_state_d == TX_LAST_LOAD);
            oe_b_d = (tx_state_d == TX_IDLE);
        end
    end

    // TX state, counters, shifter and registered frame sync / output enable
    always_ff @(posedge PCLK or negedge CLEAR_B) begin
        if (!CLEAR_B) begin
            tx_state_q  <= TX_IDLE;
            tx_cnt_q    <= '0;
            shift_out_q <= '0;
            SSPFSSOUT   <= 1'b0;
            SSPOE_B     <= 1'b1;
        end else begin
            tx_state_q  <= tx_state_d;
            tx_cnt_q    <= tx_cnt_d;
            shift_out_q <= shift_out_d;
            SSPFSSOUT   <= fss_d;
            SSPOE_B     <= oe_b_d;
        end
    end

    // FIFO pop coincides with the edge that captures TxData
    assign TxNextWord = tick && ((tx_state_q == TX_LOAD) || (tx_state_q == TX_LAST_LOAD));

    assign SSPTXD = (LSB_FIRST != 0) ? shift_out_q[0] : shift_out_q[WIDTH-1];

    // RX source select: loopback uses the internal TX signals
    assign rx_clk = LOOPBACK ? SSPCLKOUT : SSPCLKIN;
    assign rx_fss = LOOPBACK ? SSPFSSOUT : SSPFSSIN;
    assign rx_dat = LOOPBACK ? SSPTXD    : SSPRXD;
    assign fall   = clk_prev & ~rx_clk;

    // RX next-state: advances only on a falling serial clock
    always_comb begin
        rx_state_d = rx_state_q;
        rx_cnt_d   = rx_cnt_q;
        shift_in_d = shift_in_q;
        rx_data_d  = RxData;
        rx_push_d  = 1'b0;
        if (fall) begin
            case (rx_state_q)
                RX_IDLE: begin
                    if (rx_fss) begin
                        rx_state_d = RX_ACTIVE;
                        rx_cnt_d   = CNT_W'(WIDTH);
                    end
                end
                RX_ACTIVE: begin
                    if (LSB_FIRST != 0) begin
                        shift_in_d = {rx_dat, shift_in_q[WIDTH-1:1]};
                    end else begin
                        shift_in_d = {shift_in_q[WIDTH-2:0], rx_dat};
                    end
                    rx_cnt_d = rx_cnt_q - CNT_W'(1);
                    if (rx_cnt_q == CNT_W'(1)) begin
                        rx_data_d = shift_in_d;
                        rx_push_d = 1'b1;
                        if (rx_fss) begin
                            rx_cnt_d = CNT_W'(WIDTH);
                        end else begin
                            rx_state_d = RX_IDLE;
                        end
                    end
                end
                default: begin
                    rx_state_d = RX_IDLE;
                end
            endcase
        end
    end

    // RX state, shifter, received word and push strobe
    always_ff @(posedge PCLK or negedge CLEAR_B) begin
        if (!CLEAR_B) begin
            rx_state_q <= RX_IDLE;
            rx_cnt_q   <= '0;
            shift_in_q <= '0;
            clk_prev   <= 1'b0;
            RxData     <= '0;
            RxNextWord <= 1'b0;
        end else begin
            rx_state_q <= rx_state_d;
            rx_cnt_q   <= rx_cnt_d;
            shift_in_q <= shift_in_d;
            clk_prev   <= rx_clk;
            RxData     <= rx_data_d;
            RxNextWord <= rx_push_d;
        end
    end

endmodule

// File: tb/tb_ssp_serdes_param.sv
// Directed bench for ssp_serdes_param: 8-bit MSB-first DIV=2 and 12-bit LSB-first DIV=4 instances.
module tb_ssp_serdes_param;

    logic PCLK = 1'b0;
    logic CLEAR_B = 1'b0;

    always #5 PCLK = ~PCLK;

    // 8-bit instance signals
    logic       clkin8 = 1'b0, fssin8 = 1'b0, rxd8 = 1'b0, lb8 = 1'b1;
    logic [7:0] txdata8 = '0;
    logic       empty8 = 1'b1;
    logic       pop8, push8, sclk8, fss8, txd8, oeb8;
    logic [7:0] rxdata8;

    // 12-bit instance signals
    logic        clkin12 = 1'b0, fssin12 = 1'b0, rxd12 = 1'b0, lb12 = 1'b1;
    logic [11:0] txdata12 = '0;
    logic        empty12 = 1'b1;
    logic        pop12, push12, sclk12, fss12, txd12, oeb12;
    logic [11:0] rxdata12;

    ssp_serdes_param #(.WIDTH(8), .DIV(2), .LSB_FIRST(0)) dut8 (
        .PCLK(PCLK), .CLEAR_B(CLEAR_B),
        .SSPCLKIN(clkin8), .SSPFSSIN(fssin8), .SSPRXD(rxd8), .LOOPBACK(lb8),
        .TxData(txdata8), .TxIsEmpty(empty8), .TxNextWord(pop8),
        .RxData(rxdata8), .RxNextWord(push8),
        .SSPCLKOUT(sclk8), .SSPFSSOUT(fss8), .SSPTXD(txd8), .SSPOE_B(oeb8)
    );

    ssp_serdes_param #(.WIDTH(12), .DIV(4), .LSB_FIRST(1)) dut12 (
        .PCLK(PCLK), .CLEAR_B(CLEAR_B),
        .SSPCLKIN(clkin12), .SSPFSSIN(fssin12), .SSPRXD(rxd12), .LOOPBACK(lb12),
        .TxData(txdata12), .TxIsEmpty(empty12), .TxNextWord(pop12),
        .RxData(rxdata12), .RxNextWord(push12),
        .SSPCLKOUT(sclk12), .SSPFSSOUT(fss12), .SSPTXD(txd12), .SSPOE_B(oeb12)
    );

    int checks = 0;
    int errors = 0;

    // TX FIFO models and observation state
    logic [7:0]  q8[$];
    logic [11:0] q12[$];
    logic [15:0] rxlog8[$];
    logic [15:0] rxlog12[$];
    logic        pend8 = 1'b0, pend12 = 1'b0;
    logic        prevclk8 = 1'b0, prevclk12 = 1'b0;
    logic        started8 = 1'b0, started12 = 1'b0;
    int          pops8 = 0, pushes8 = 0, np8 = 0, oelow8 = 0, oe0cyc8 = 0;
    int          pops12 = 0, pushes12 = 0, np12 = 0, oelow12 = 0, nclk12 = 0;
    logic [63:0] txdl8 = '0, fssl8 = '0, txdl12 = '0, fssl12 = '0;
    logic [7:0]  clkl12 = '0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] pack_msb(input logic [63:0] v, input int from, input int n);
        logic [15:0] r;
        r = '0;
        for (int i = 0; i < n; i++) r = {r[14:0], v[6'(from + i)]};
        return r;
    endfunction

    function automatic logic [15:0] pack_lsb(input logic [63:0] v, input int from, input int n);
        logic [15:0] r;
        r = '0;
        for (int i = 0; i < n; i++) r[4'(i)] = v[6'(from + i)];
        return r;
    endfunction

    task automatic clr8();
        pops8 = 0; pushes8 = 0; np8 = 0; oelow8 = 0; oe0cyc8 = 0;
        started8 = 1'b0; txdl8 = '0; fssl8 = '0; rxlog8.delete();
    endtask

    task automatic clr12();
        pops12 = 0; pushes12 = 0; np12 = 0; oelow12 = 0; nclk12 = 0;
        started12 = 1'b0; txdl12 = '0; fssl12 = '0; clkl12 = '0; rxlog12.delete();
    endtask

    task automatic push8w(input logic [7:0] w);
        q8.push_back(w);
        txdata8 = q8[0];
        empty8  = 1'b0;
    endtask

    task automatic push12w(input logic [11:0] w);
        q12.push_back(w);
        txdata12 = q12[0];
        empty12  = 1'b0;
    endtask

    // One PCLK cycle: serve FIFO pops, then sample both instances #1 after the edge
    task automatic cyc();
        @(posedge PCLK);
        #1;
        if (pend8 && q8.size() > 0) q8.delete(0);
        if (pend12 && q12.size() > 0) q12.delete(0);
        txdata8  = (q8.size() > 0) ? q8[0] : 8'h00;
        empty8   = (q8.size() == 0);
        txdata12 = (q12.size() > 0) ? q12[0] : 12'h000;
        empty12  = (q12.size() == 0);

        pend8 = pop8;
        if (pop8) pops8++;
        if (push8) begin pushes8++; rxlog8.push_back(16'(rxdata8)); end
        if (!oeb8) oe0cyc8++;
        if (sclk8 && !prevclk8) begin
            if (!oeb8) started8 = 1'b1;
            if (started8 && np8 < 64) begin
                txdl8[6'(np8)] = txd8;
                fssl8[6'(np8)] = fss8;
                if (!oeb8) oelow8++;
                np8++;
            end
        end
        prevclk8 = sclk8;

        pend12 = pop12;
        if (pop12) pops12++;
        if (push12) begin pushes12++; rxlog12.push_back(16'(rxdata12)); end
        if (sclk12 && !prevclk12) begin
            if (!oeb12) started12 = 1'b1;
            if (started12 && np12 < 64) begin
                txdl12[6'(np12)] = txd12;
                fssl12[6'(np12)] = fss12;
                if (!oeb12) oelow12++;
                np12++;
            end
        end
        if (started12 && nclk12 < 8) begin
            clkl12[3'(nclk12)] = sclk12;
            nclk12++;
        end
        prevclk12 = sclk12;
    endtask

    // One external serial bit: clock high two PCLKs, then low two PCLKs (fall samples fss/d)
    task automatic ext_bit(input logic f, input logic d);
        fssin8 = f;
        rxd8   = d;
        clkin8 = 1'b1;
        repeat (2) cyc();
        clkin8 = 1'b0;
        repeat (2) cyc();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        logic [7:0] w8;
        int n;

        // Reset state
        repeat (3) @(posedge PCLK);
        #3;
        check("rst8_out", 32'({sclk8, fss8, txd8, pop8, push8, oeb8}), 32'h01);
        check("rst8_rxdata", 32'(rxdata8), 32'h0);
        check("rst12_out", 32'({sclk12, fss12, txd12, pop12, push12, oeb12}), 32'h01);
        check("rst12_rxdata", 32'(rxdata12), 32'h0);
        CLEAR_B = 1'b1;

        // Scenario 1: single word 0xA5 in loopback
        clr8();
        push8w(8'hA5);
        repeat (30) cyc();
        check("s1_fss_count", 32'($countones(fssl8)), 32'd1);
        check("s1_fss_first", 32'(fssl8[0]), 32'd1);
        check("s1_oe_periods", 32'(oelow8), 32'd9);
        check("s1_txd_bits", 32'(pack_msb(txdl8, 1, 8)), 32'hA5);
        check("s1_pops", 32'(pops8), 32'd1);
        check("s1_pushes", 32'(pushes8), 32'd1);
        check("s1_rx_word", 32'((rxlog8.size() > 0) ? rxlog8[0] : 16'hFFFF), 32'hA5);
        check("s1_rx_hold", 32'(rxdata8), 32'hA5);

        // Scenario 2: back-to-back 0x3C then 0xC3
        clr8();
        push8w(8'h3C);
        push8w(8'hC3);
        repeat (50) cyc();
        check("s2_fss_count", 32'($countones(fssl8)), 32'd2);
        check("s2_fss_no_gap", 32'(fssl8[8]), 32'd1);
        check("s2_txd_word0", 32'(pack_msb(txdl8, 1, 8)), 32'h3C);
        check("s2_txd_word1", 32'(pack_msb(txdl8, 9, 8)), 32'hC3);
        check("s2_oe_periods", 32'(oelow8), 32'd17);
        check("s2_pops", 32'(pops8), 32'd2);
        check("s2_pushes", 32'(pushes8), 32'd2);
        check("s2_rx_word0", 32'((rxlog8.size() > 0) ? rxlog8[0] : 16'hFFFF), 32'h3C);
        check("s2_rx_word1", 32'((rxlog8.size() > 1) ? rxlog8[1] : 16'hFFFF), 32'hC3);

        // Scenario 3: 12-bit, DIV=4, LSB-first word 0x5A3
        clr12();
        push12w(12'h5A3);
        repeat (80) cyc();
        check("s3_clk_shape", 32'(clkl12), 32'h33);
        check("s3_first_bits", 32'(pack_msb(txdl12, 1, 4)), 32'hC);
        check("s3_txd_word", 32'(pack_lsb(txdl12, 1, 12)), 32'h5A3);
        check("s3_fss_count", 32'($countones(fssl12)), 32'd1);
        check("s3_oe_periods", 32'(oelow12), 32'd13);
        check("s3_pops", 32'(pops12), 32'd1);
        check("s3_pushes", 32'(pushes12), 32'd1);
        check("s3_rx_word", 32'((rxlog12.size() > 0) ? rxlog12[0] : 16'hFFFF), 32'h5A3);

        // Scenario 4: external frame 0x81, then idle falls must not form a word
        lb8 = 1'b0;
        clr8();
        w8 = 8'h81;
        ext_bit(1'b1, 1'b0);
        for (int i = 7; i >= 0; i--) ext_bit(1'b0, w8[3'(i)]);
        repeat (4) cyc();
        check("s4_pushes", 32'(pushes8), 32'd1);
        check("s4_rx_word", 32'((rxlog8.size() > 0) ? rxlog8[0] : 16'hFFFF), 32'h81);
        check("s4_pops", 32'(pops8), 32'd0);
        for (int i = 0; i < 8; i++) ext_bit(1'b0, 1'b1);
        repeat (4) cyc();
        check("s4_idle_pushes", 32'(pushes8), 32'd1);
        check("s4_rx_hold", 32'(rxdata8), 32'h81);

        // Scenario 5: asynchronous reset in mid-frame
        lb8 = 1'b1;
        clr8();
        push8w(8'hFF);
        n = 0;
        while (np8 < 5 && n < 100) begin
            cyc();
            n++;
        end
        check("s5_reach_bit4", 32'(np8 >= 5), 32'd1);
        check("s5_pre_out", 32'({txd8, oeb8}), 32'h2);
        #2;
        CLEAR_B = 1'b0;
        #1;
        check("s5_async_out", 32'({sclk8, fss8, txd8, pop8, push8, oeb8}), 32'h01);
        check("s5_async_rxdata", 32'(rxdata8), 32'h0);
        pend8 = 1'b0;
        q8.delete();
        empty8 = 1'b1;
        repeat (3) cyc();
        clr8();
        CLEAR_B = 1'b1;
        repeat (20) cyc();
        check("s5_post_pops", 32'(pops8), 32'd0);
        check("s5_post_oe", 32'(oe0cyc8), 32'd0);
        check("s5_post_pushes", 32'(pushes8), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ssp_serdes_param.md
SSP_SERDES_PARAM -- requirements
Module: ssp_serdes_param

Interface
REQ-001 SHALL have parameter WIDTH, default 8, frame word width; legal range 4..16.
REQ-002 SHALL have parameter DIV, default 2, PCLK cycles per SSPCLKOUT period; legal values are even and >=2.
REQ-003 SHALL have parameter LSB_FIRST, default 0; 0 sends and receives MSB first, 1 sends and receives LSB first.
REQ-004 SHALL have ports:
  - PCLK  in  1  sole clock; all flops on its rising edge.
  - CLEAR_B  in  1  asynchronous active-low reset.
  - SSPCLKIN  in  1  external serial clock.
  - SSPFSSIN  in  1  external frame sync.
  - SSPRXD  in  1  external serial data.
  - LOOPBACK  in  1  1 routes SSPCLKOUT, SSPFSSOUT and SSPTXD internally to the RX path; external RX inputs ignored.
  - TxData  in  WIDTH  head word of the TX FIFO.
  - TxIsEmpty  in  1  TX FIFO empty.
  - TxNextWord  out  1  TX FIFO pop strobe.
  - RxData  out  WIDTH  last completed received word.
  - RxNextWord  out  1  RX FIFO push strobe.
  - SSPCLKOUT  out  1  divided serial clock.
  - SSPFSSOUT  out  1  transmit frame sync.
  - SSPTXD  out  1  transmit serial data.
  - SSPOE_B  out  1  active-low TXD output enable.

Function
REQ-005 SHALL run div_cnt 0..DIV-1, wrapping to 0; SSPCLKOUT SHALL be a register set on the edge where div_cnt wraps to 0 and cleared on the edge where div_cnt becomes DIV/2 (50% duty cycle).
REQ-006 SHALL define tick = (div_cnt == DIV-1); every TX state, shift and bit-count update SHALL occur only on tick edges, so TX outputs change coincident with SSPCLKOUT rising.
REQ-007 SHALL implement the TX FSM with states IDLE, LOAD, SHIFT, LAST and LAST_LOAD; all transitions SHALL take effect on tick only:
  - IDLE -> LOAD if TxIsEmpty==0, else stay in IDLE.
  - LOAD -> SHIFT, with tx_cnt=WIDTH-1.
  - SHIFT: decrement tx_cnt; when tx_cnt==1, go to LAST_LOAD if TxIsEmpty==0, else to LAST.
  - LAST -> IDLE.
  - LAST_LOAD -> SHIFT, with tx_cnt=WIDTH-1.
REQ-008 SHALL load shift_out<=TxData on tick in LOAD and in LAST_LOAD; on every other tick, shift_out SHALL shift one place toward the output end, zero-filled.
REQ-009 SHALL drive SSPTXD as shift_out[WIDTH-1] when LSB_FIRST=0 and as shift_out[0] when LSB_FIRST=1.
REQ-010 SHALL assert SSPFSSOUT exactly while the TX state is LOAD or LAST_LOAD (one SSPCLKOUT period per word), so back-to-back frames have no idle gap.
REQ-011 SHALL assert TxNextWord combinationally as tick AND (state is LOAD or LAST_LOAD): exactly one PCLK pulse per word, on the same edge that TxData is captured.
REQ-012 SHALL drive SSPOE_B as a register: 0 while the TX state is not IDLE, 1 in IDLE, updated on the same edge as the TX state.
REQ-013 SHALL sample TxIsEmpty only on tick edges; changes between ticks have no effect.
REQ-014 SHALL select the RX sources: internal TX signals when LOOPBACK=1, otherwise SSPCLKIN, SSPFSSIN and SSPRXD.
REQ-015 SHALL register the selected clock as clk_prev and define fall = clk_prev & ~clk.
REQ-016 SHALL implement the RX FSM with states IDLE and ACTIVE, advancing on fall only:
  - IDLE -> ACTIVE with rx_cnt=WIDTH if FSS==1; no data is shifted on this fall.
  - ACTIVE: shift in the data bit (MSB-first or LSB-first per LSB_FIRST) and decrement rx_cnt.
  - When rx_cnt reaches 0: copy the word to RxData; then stay in ACTIVE with rx_cnt=WIDTH if FSS==1 at that fall, else go to IDLE.
REQ-017 SHALL pulse RxNextWord high for exactly one PCLK, on the edge after the fall that completes a word, with RxData already valid at that time.
REQ-018 SHALL hold RxData between completed words.

Reset
REQ-019 SHALL, while CLEAR_B==0 and asynchronously:
  - Put both FSMs in IDLE.
  - Zero div_cnt, tx_cnt, rx_cnt, shift_out, shift_in, clk_prev and RxData.
  - Drive SSPCLKOUT=0, SSPFSSOUT=0, SSPTXD=0, TxNextWord=0, RxNextWord=0 and SSPOE_B=1.
REQ-020 SHALL, after CLEAR_B deasserts, start div_cnt at 0 and start no frame until a tick sees TxIsEmpty==0.

Verification
REQ-021 SHALL cover scenario 1: WIDTH=8, DIV=2, LOOPBACK=1, single word 0xA5 -> SSPFSSOUT high for 1 period; SSPTXD 1,0,1,0,0,1,0,1; SSPOE_B low for 9 periods; one TxNextWord; RxData=0xA5 with one RxNextWord.
REQ-022 SHALL cover scenario 2: words 0x3C then 0xC3 with TxIsEmpty held low until the second pop -> SSPFSSOUT high during bit 0 of 0x3C; no gap between frames; 2 TxNextWord and 2 RxNextWord pulses; RxData sequence 0x3C, 0xC3.
REQ-023 SHALL cover scenario 3: WIDTH=12, DIV=4, LSB_FIRST=1, LOOPBACK=1, word 0x5A3 -> SSPCLKOUT 2 PCLK high / 2 PCLK low; first bits on SSPTXD 1,1,0,0; RxData=0x5A3.
REQ-024 SHALL cover scenario 4: LOOPBACK=0, external frame with SSPFSSIN=1 at the start fall, then 8 bits of 0x81, SSPFSSIN=0 at the last fall -> RxData=0x81, one RxNextWord, RX FSM back in IDLE.
REQ-025 SHALL cover scenario 5: CLEAR_B low after 3 bits sent -> all outputs take their reset values with no PCLK edge; after release with TxIsEmpty=1, no TxNextWord and SSPOE_B stays 1.
